// File: rtl/video_hmirror.sv
// video_hmirror: Avalon-ST RGB565 stage that emits each line reversed (mirror_en=1) or in order.
// Ports: clk; reset (async, active-low); mirror_en (sampled when a line starts draining);
//   in_data/in_sop/in_eop/in_valid/in_ready: sink; out_data/out_sop/out_eop/out_valid/out_ready: source;
//   err_sop: sticky flag for an SOP that arrived mid-line; err_clear: clears err_sop and wins over a same-cycle set.
module video_hmirror #(
  parameter int LINE_WIDTH = 320,
  parameter int ADDR_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mirror_en,
  input  logic [15:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_sop,
  input  logic        err_clear
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_e;
  typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_e;
  localparam logic [ADDR_W-1:0] XMAX = ADDR_W'(LINE_WIDTH - 1);
  logic [15:0] mem [2**(ADDR_W+1)];
  bank_e bank_q [2];
  logic [ADDR_W-1:0] last_q [2];
  logic [1:0] bsop_q, beop_q;
  logic wbank_q, rbank_q, mir_q, err_q, valid_q, sop_q, eop_q;
  logic [ADDR_W-1:0] wr_x_q, addr_q, cnt_q;
  logic [15:0] data_q;
  rd_e rd_q;
  logic wr_acc, sop_mid, wr_close, rd_done, rd_start, rd_load, sbank;
  logic [ADDR_W-1:0] wx, nxt, start, ld_idx;
  // in_ready is forced low while reset is held so every output reads 0 in reset
  assign in_ready = reset && (bank_q[wbank_q] == EMPTY || bank_q[wbank_q] == FILLING);
  assign out_data = data_q;
  assign out_sop = sop_q;
  assign out_eop = eop_q;
  assign out_valid = valid_q;
  assign err_sop = err_q;
  always_comb begin
    wr_acc = in_valid && in_ready;
    // a mid-line SOP restarts the current bank at pixel 0, discarding the partial line
    wx = in_sop ? '0 : wr_x_q;
    sop_mid = wr_acc && in_sop && wr_x_q != '0;
    wr_close = wr_acc && (wx == XMAX || in_eop);
    rd_done = rd_q == STREAM && out_ready && cnt_q == last_q[rbank_q];
    // chain straight into the other bank when it is already full: one bubble between lines
    rd_start = (rd_q == IDLE && bank_q[rbank_q] == FULL) || (rd_done && bank_q[!rbank_q] == FULL);
    sbank = rd_done ? !rbank_q : rbank_q;
    start = mirror_en ? last_q[sbank] : '0;
    // the output register doubles as the RAM read register, so a load is also the prefetch
    rd_load = rd_q == PRIME || (rd_q == STREAM && out_ready && !rd_done);
    ld_idx = rd_q == PRIME ? '0 : cnt_q + 1'b1;
    nxt = mir_q ? addr_q - 1'b1 : addr_q + 1'b1;
  end
  always_ff @(posedge clk)
    if (wr_acc) mem[{wbank_q, wx}] <= in_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      last_q[0] <= '0;
      last_q[1] <= '0;
      bsop_q <= '0;
      beop_q <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wr_x_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      mir_q <= 1'b0;
      err_q <= 1'b0;
      rd_q <= IDLE;
      data_q <= '0;
      valid_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_x_q <= wr_close ? '0 : wx + 1'b1;
        if (wx == '0) bsop_q[wbank_q] <= in_sop;
        if (wr_close) begin
          last_q[wbank_q] <= wx;
          beop_q[wbank_q] <= in_eop;
          wbank_q <= !wbank_q;
        end
      end
      err_q <= !err_clear && (err_q || sop_mid);
      for (int b = 0; b < 2; b++) begin
        if (wr_acc && wbank_q == 1'(b)) bank_q[b] <= wr_close ? FULL : FILLING;
        if (rd_start && sbank == 1'(b)) bank_q[b] <= DRAINING;
        if (rd_done && rbank_q == 1'(b)) bank_q[b] <= EMPTY;
      end
      if (rd_done) rbank_q <= !rbank_q;
      if (rd_start) begin
        rd_q <= PRIME;
        mir_q <= mirror_en;
        addr_q <= start;
      end else if (rd_done) rd_q <= IDLE;
      else if (rd_q == PRIME) rd_q <= STREAM;
      if (rd_load) begin
        data_q <= mem[{rbank_q, addr_q}];
        addr_q <= nxt;
        cnt_q <= ld_idx;
        sop_q <= bsop_q[rbank_q] && ld_idx == '0;
        eop_q <= beop_q[rbank_q] && ld_idx == last_q[rbank_q];
        valid_q <= 1'b1;
      end else if (rd_done) begin
        valid_q <= 1'b0;
        sop_q <= 1'b0;
        eop_q <= 1'b0;
      end
    end
endmodule

// File: tb/tb_video_hmirror.sv
// tb_video_hmirror: directed vectors plus hand-written sequences for video_hmirror with LINE_WIDTH=4.
module tb_video_hmirror;
  logic clk = 0, reset = 0, mirror_en = 0, in_sop = 0, in_eop = 0, in_valid = 0, out_ready = 1, err_clear = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_sop, out_eop, out_valid, err_sop;
  logic [15:0] out_data;
  int n_pass = 0, n_total = 0, cyc = 0, acc_cnt = 0;
  bit drv_done;
  typedef struct { logic [15:0] d; logic s; logic e; int c; } beat_t;
  beat_t outq[$];
  typedef struct { logic mir; int n; logic sop; logic eop; logic [63:0] px; logic [63:0] ex; } vec_t;
  vec_t vecs[7];

  video_hmirror #(.LINE_WIDTH(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .mirror_en(mirror_en),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready),
    .err_sop(err_sop), .err_clear(err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (reset) begin
      if (out_valid && out_ready) outq.push_back('{out_data, out_sop, out_eop, cyc});
      if (in_valid && in_ready) acc_cnt++;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic put(input logic [15:0] d, input logic s, input logic e);
    int t = 0;
    in_data = d;
    in_sop = s;
    in_eop = e;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) chk("put in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_sop = 0;
    in_eop = 0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (outq.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wait_out", outq.size() >= n, 1);
  endtask

  function automatic logic [15:0] lpx(input int l, input int i);
    return 16'(256 * (l + 1) + i);
  endfunction

  initial begin
    vecs[0] = '{1'b1, 4, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'hDDDD_CCCC_BBBB_AAAA};
    vecs[1] = '{1'b0, 4, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD};
    vecs[2] = '{1'b1, 2, 1'b1, 1'b1, 64'h1111_2222_0000_0000, 64'h2222_1111_0000_0000};
    vecs[3] = '{1'b1, 3, 1'b0, 1'b1, 64'h0123_4567_89AB_0000, 64'h89AB_4567_0123_0000};
    vecs[4] = '{1'b0, 4, 1'b0, 1'b0, 64'hF800_07E0_001F_FFFF, 64'hF800_07E0_001F_FFFF};
    vecs[5] = '{1'b1, 1, 1'b1, 1'b1, 64'hBEEF_0000_0000_0000, 64'hBEEF_0000_0000_0000};
    vecs[6] = '{1'b1, 4, 1'b0, 1'b0, 64'h0001_0002_0003_0004, 64'h0004_0003_0002_0001};
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst err_sop", err_sop, 0);
    chk("rst out_bus", {out_sop, out_eop, out_data}, 0);
    reset = 1;
    #1;
    chk("rel in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      mirror_en = vecs[i].mir;
      outq.delete();
      for (int k = 0; k < vecs[i].n; k++)
        put(vecs[i].px[63-16*k -: 16], vecs[i].sop && k == 0, vecs[i].eop && k == vecs[i].n - 1);
      @(negedge clk);
      chk($sformatf("v%0d lat+0", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d lat+1", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d lat+2", i), out_valid, 1);
      mirror_en = ~vecs[i].mir;
      wait_out(vecs[i].n);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d count", i), outq.size(), vecs[i].n);
      for (int k = 0; k < vecs[i].n && k < outq.size(); k++)
        chk($sformatf("v%0d beat%0d", i, k), {outq[k].s, outq[k].e, outq[k].d},
            {vecs[i].sop && k == 0, vecs[i].eop && k == vecs[i].n - 1, vecs[i].ex[63-16*k -: 16]});
    end

    // three back-to-back mirrored lines: one bubble between lines
    @(posedge clk);
    #1;
    mirror_en = 1;
    outq.delete();
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 4; i++) put(lpx(l, i), l == 0 && i == 0, l == 2 && i == 3);
    wait_out(12);
    repeat (6) @(negedge clk);
    chk("stream count", outq.size(), 12);
    for (int j = 0; j < 12 && j < outq.size(); j++)
      chk($sformatf("stream beat%0d", j), {outq[j].s, outq[j].e, outq[j].d}, {j == 0, j == 11, lpx(j / 4, 3 - j % 4)});
    if (outq.size() == 12) begin
      chk("stream gap01", outq[4].c - outq[3].c, 2);
      chk("stream gap12", outq[8].c - outq[7].c, 2);
      chk("stream line0", outq[3].c - outq[0].c, 3);
    end

    // back-pressure: both banks fill, in_ready drops, head beat is held
    @(posedge clk);
    #1;
    outq.delete();
    out_ready = 0;
    acc_cnt = 0;
    drv_done = 0;
    fork
      begin
        for (int l = 0; l < 3; l++)
          for (int i = 0; i < 4; i++) put(lpx(l, i), l == 0 && i == 0, l == 2 && i == 3);
        drv_done = 1;
      end
    join_none
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 7) chk($sformatf("hold%0d", k), {out_valid, out_sop, out_data}, {1'b1, 1'b1, lpx(0, 3)});
    end
    chk("stall accepted", acc_cnt, 8);
    chk("stall in_ready", in_ready, 0);
    out_ready = 1;
    for (int t = 0; t < 200 && !drv_done; t++) @(negedge clk);
    chk("stall drv_done", drv_done, 1);
    wait_out(12);
    repeat (6) @(negedge clk);
    chk("stall count", outq.size(), 12);
    for (int j = 0; j < 12 && j < outq.size(); j++)
      chk($sformatf("stall beat%0d", j), {outq[j].s, outq[j].e, outq[j].d}, {j == 0, j == 11, lpx(j / 4, 3 - j % 4)});

    // SOP at wr_x=2 drops the partial line and flags err_sop
    @(posedge clk);
    #1;
    mirror_en = 0;
    outq.delete();
    put(16'h0A00, 1, 0);
    put(16'h0A01, 0, 0);
    put(16'h0B00, 1, 0);
    chk("err_sop set", err_sop, 1);
    put(16'h0B01, 0, 0);
    put(16'h0B02, 0, 0);
    put(16'h0B03, 0, 1);
    wait_out(4);
    repeat (4) @(negedge clk);
    chk("midsop count", outq.size(), 4);
    for (int j = 0; j < 4 && j < outq.size(); j++)
      chk($sformatf("midsop beat%0d", j), {outq[j].s, outq[j].e, outq[j].d}, {j == 0, j == 3, 16'(16'h0B00 + j)});
    err_clear = 1;
    @(posedge clk);
    #1;
    err_clear = 0;
    chk("err_sop clear", err_sop, 0);
    outq.delete();
    err_clear = 1;
    put(16'h0C00, 1, 0);
    put(16'h0C01, 0, 0);
    put(16'h0D00, 1, 0);
    chk("err_clear priority", err_sop, 0);
    err_clear = 0;
    put(16'h0D01, 0, 0);
    put(16'h0D02, 0, 1);
    wait_out(3);
    repeat (4) @(negedge clk);
    chk("prio count", outq.size(), 3);
    if (outq.size() > 0) chk("prio beat0", {outq[0].s, outq[0].d}, {1'b1, 16'h0D00});

    // reset in the middle of a drain
    @(posedge clk);
    #1;
    mirror_en = 1;
    out_ready = 0;
    outq.delete();
    for (int i = 0; i < 4; i++) put(lpx(3, i), i == 0, i == 3);
    repeat (3) @(negedge clk);
    chk("pre-reset out_valid", out_valid, 1);
    #2;
    reset = 0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst out_bus", {out_sop, out_eop, out_data}, 0);
    @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("post-rst in_ready", in_ready, 1);
    out_ready = 1;
    repeat (10) @(negedge clk);
    chk("post-rst no output", outq.size(), 0);
    chk("post-rst out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
